// File: rtl/pat_pkg.sv
// Shared definitions for the pattern generator / detector pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pat_pkg;

  // Default symbol width, equal to the generator data width.
  localparam int SYM_W_DEF = 4;

  // Detector control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/sym_window.sv
// Sliding window of the last SEQ_LEN symbols; newest symbol in the low slice.
// Latency: one cycle from i_shift to the updated o_win.
// Backpressure: none; i_shift low simply holds the window.
module sym_window
  import pat_pkg::*;
#(
  parameter int SEQ_LEN = 3,
  parameter int SYM_W   = SYM_W_DEF
) (
  input  logic                     clk,
  input  logic                     i_clr,
  input  logic                     i_shift,
  input  logic [SYM_W-1:0]         i_sym,
  output logic [SEQ_LEN*SYM_W-1:0] o_win
);

  localparam int WIN_W = SEQ_LEN * SYM_W;

  logic [WIN_W-1:0] r_win;

  // Clear has priority; otherwise shift the oldest symbol out the top.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_win <= '0;
    end else if (i_shift) begin
      r_win <= {r_win[WIN_W-SYM_W-1:0], i_sym};
    end
  end

  assign o_win = r_win;

endmodule

// File: rtl/pat_det.sv
// Detects a loadable SEQ_LEN-symbol target in the symbol stream (overlaps count).
// Latency: match pulses one cycle after the edge sampling the final symbol.
// Backpressure: none; in_valid low is a gap that holds all state.
module pat_det
  import pat_pkg::*;
#(
  parameter int SYM_W   = SYM_W_DEF,
  parameter int SEQ_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     en,
  input  logic                     load,
  input  logic [SEQ_LEN*SYM_W-1:0] pattern_in,
  input  logic                     in_valid,
  input  logic [SYM_W-1:0]         data_in,
  input  logic                     clr_cnt,
  output logic                     match,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     cnt_sat,
  output logic                     busy
);

  localparam int                WIN_W     = SEQ_LEN * SYM_W;
  localparam int                FILL_W    = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_MAX - 1'b1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [FILL_W-1:0]   r_fill;
  logic [FILL_W-1:0]   w_fill_nxt;
  logic [WIN_W-1:0]    r_target;
  logic [WIN_W-1:0]    w_win;
  logic [WIN_W-1:0]    w_win_nxt;
  logic                w_accept;
  logic                w_hit;
  logic                r_match;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_sat;

  sym_window #(
    .SEQ_LEN (SEQ_LEN),
    .SYM_W   (SYM_W)
  ) u_window (
    .clk     (clk),
    .i_clr   (res),
    .i_shift (w_accept),
    .i_sym   (data_in),
    .o_win   (w_win)
  );

  // Window as it will look once the current symbol is shifted in; compared
  // on the accepting edge so the pulse lands exactly one cycle later.
  assign w_win_nxt = {w_win[WIN_W-SYM_W-1:0], data_in};

  // Next-state, symbol acceptance and compare; load then en take priority.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_accept    = 1'b0;
    w_hit       = 1'b0;
    if (load) begin
      // New target: restart the fill and drop any symbol offered now.
      w_fill_nxt  = '0;
      w_state_nxt = en ? FILL : IDLE;
    end else if (!en) begin
      w_fill_nxt  = '0;
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_fill_nxt  = '0;
          w_state_nxt = FILL;
        end
        FILL: begin
          if (in_valid) begin
            w_accept = 1'b1;
            if (r_fill == FILL_LAST) begin
              w_fill_nxt  = '0;
              w_state_nxt = RUN;
              w_hit       = (w_win_nxt == r_target);
            end else begin
              w_fill_nxt = r_fill + FILL_W'(1);
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            w_accept = 1'b1;
            w_hit    = (w_win_nxt == r_target);
          end
        end
        default: begin
          w_fill_nxt  = '0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, fill count and target registers.
  always_ff @(posedge clk) begin
    if (res) begin
      r_state  <= IDLE;
      r_fill   <= '0;
      r_target <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
      if (load) begin
        r_target <= pattern_in;
      end
    end
  end

  // Match pulse and saturating counter; a clear beats a same-edge match.
  always_ff @(posedge clk) begin
    if (res) begin
      r_match <= 1'b0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (clr_cnt) begin
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else if (w_hit && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_PRE) begin
          r_sat <= 1'b1;
        end
      end
    end
  end

  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_pat_det.sv
// Bench for pat_det: directed scenarios plus random traffic against a
// history-queue reference model; two DUTs share stimulus (CNT_W=8 and 2).
module tb_pat_det;

  logic        clk = 1'b0;
  logic        res, en, load, in_valid, clr_cnt;
  logic [11:0] pattern_in;
  logic [3:0]  data_in;

  logic        match8, sat8, busy8;
  logic [7:0]  cnt8;
  logic        match2, sat2, busy2;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  pat_det #(.SYM_W(4), .SEQ_LEN(3), .CNT_W(8)) dut8 (
    .clk(clk), .res(res), .en(en), .load(load), .pattern_in(pattern_in),
    .in_valid(in_valid), .data_in(data_in), .clr_cnt(clr_cnt),
    .match(match8), .match_cnt(cnt8), .cnt_sat(sat8), .busy(busy8)
  );

  pat_det #(.SYM_W(4), .SEQ_LEN(3), .CNT_W(2)) dut2 (
    .clk(clk), .res(res), .en(en), .load(load), .pattern_in(pattern_in),
    .in_valid(in_valid), .data_in(data_in), .clr_cnt(clr_cnt),
    .match(match2), .match_cnt(cnt2), .cnt_sat(sat2), .busy(busy2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: "armed" flag plus the symbols accepted since the last restart.
  bit          m_armed;
  logic [3:0]  m_hist[$];
  logic [11:0] m_tgt;
  bit          m_match;
  int          m_cnt8, m_cnt2;
  bit          m_sat8, m_sat2;
  logic [11:0] cur_pat;

  function automatic bit tail_is_target();
    if (m_hist.size() != 3) return 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m_hist[i] != m_tgt[(2 - i) * 4 +: 4]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit hit;
    hit = 1'b0;
    if (res) begin
      m_armed = 1'b0; m_hist.delete(); m_tgt = '0;
      m_match = 1'b0; m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 1'b0; m_sat2 = 1'b0;
      return;
    end
    if (load) begin
      m_tgt = pattern_in; m_hist.delete(); m_armed = en;
    end else if (!en) begin
      m_armed = 1'b0; m_hist.delete();
    end else if (!m_armed) begin
      m_armed = 1'b1; m_hist.delete();
    end else if (in_valid) begin
      m_hist.push_back(data_in);
      if (m_hist.size() > 3) void'(m_hist.pop_front());
      hit = tail_is_target();
    end
    m_match = hit;
    if (clr_cnt) begin
      m_cnt8 = 0; m_sat8 = 1'b0; m_cnt2 = 0; m_sat2 = 1'b0;
    end else if (hit) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt8 == 255) m_sat8 = 1'b1;
      if (m_cnt2 < 3) m_cnt2++;
      if (m_cnt2 == 3) m_sat2 = 1'b1;
    end
  endtask

  // One clock: drive inputs, advance the model, compare #1 after the edge.
  task automatic cyc(input bit r, input bit e, input bit l, input logic [11:0] p,
                     input bit v, input logic [3:0] d, input bit c);
    res = r; en = e; load = l; pattern_in = p; in_valid = v; data_in = d; clr_cnt = c;
    @(posedge clk);
    model_edge();
    #1;
    check("match8", match8, m_match);
    check("cnt8",   cnt8,   m_cnt8);
    check("sat8",   sat8,   m_sat8);
    check("busy8",  busy8,  m_armed);
    check("match2", match2, m_match);
    check("cnt2",   cnt2,   m_cnt2);
    check("sat2",   sat2,   m_sat2);
    check("busy2",  busy2,  m_armed);
  endtask

  task automatic sym(input logic [3:0] d);   cyc(0, 1, 0, cur_pat, 1, d, 0); endtask
  task automatic gap(input int n);           for (int i = 0; i < n; i++) cyc(0, 1, 0, cur_pat, 0, 4'h0, 0); endtask
  task automatic clr();                      cyc(0, 1, 0, cur_pat, 0, 4'h0, 1); endtask
  task automatic do_load(input logic [11:0] p);
    cur_pat = p;
    cyc(0, 1, 1, p, 0, 4'h0, 0);
  endtask

  function automatic logic [3:0] pick_sym();
    case ($urandom_range(0, 3))
      0:       return 4'hA;
      1:       return 4'h5;
      2:       return 4'h3;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin
    cur_pat = 12'h000;
    m_armed = 1'b0; m_tgt = '0; m_match = 1'b0;
    m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 1'b0; m_sat2 = 1'b0;

    // Reset state.
    cyc(1, 0, 0, 12'h000, 0, 4'h0, 0);
    cyc(1, 1, 0, 12'h000, 1, 4'hA, 1);
    check("rst_match", match8, 0);
    check("rst_busy",  busy8,  0);

    // Back-to-back overlapping matches.
    do_load(12'hA5A);
    sym(4'hA); sym(4'h5); sym(4'hA); sym(4'h5); sym(4'hA);
    check("t1_cnt", cnt8, 2);
    check("t1_sat", sat8, 0);

    // Gap inside a sequence.
    clr(); do_load(12'hA5A);
    sym(4'hA); gap(3); sym(4'h5); sym(4'hA);
    check("t2_cnt", cnt8, 1);

    // Near-miss A,5,7 then a real match.
    clr(); do_load(12'hA5A);
    sym(4'h3); sym(4'hA); sym(4'h5); sym(4'h7); sym(4'hA); sym(4'h5); sym(4'hA);
    check("t3_cnt", cnt8, 1);

    // Saturation on the 2-bit counter, then clear.
    clr(); do_load(12'hA5A);
    for (int k = 0; k < 5; k++) begin sym(4'hA); sym(4'h5); sym(4'hA); end
    check("t4_cnt2", cnt2, 3);
    check("t4_sat2", sat2, 1);
    check("t4_cnt8", cnt8, 5);
    clr();
    check("t4_clr_cnt2", cnt2, 0);
    check("t4_clr_sat2", sat2, 0);

    // Load mid-sequence drops the concurrent symbol.
    do_load(12'hA5A);
    sym(4'hA); sym(4'h5);
    cur_pat = 12'h123;
    cyc(0, 1, 1, 12'h123, 1, 4'hA, 0);
    check("t5_noload_match", match8, 0);
    sym(4'h1); sym(4'h2); sym(4'h3);
    check("t5_match", match8, 1);

    // Reset mid-sequence, lone tail symbol, then a clean match.
    do_load(12'hA5A);
    sym(4'hA); sym(4'h5);
    cyc(1, 1, 0, cur_pat, 1, 4'hA, 0);
    check("t6_rst_busy", busy8, 0);
    check("t6_rst_cnt",  cnt8,  0);
    sym(4'hA); sym(4'hA);
    check("t6_lone", match8, 0);
    do_load(12'hA5A);
    sym(4'hA); sym(4'h5); sym(4'hA);
    check("t6_match", match8, 1);

    // en drop mid-sequence restarts the fill.
    sym(4'h5);
    cyc(0, 0, 0, cur_pat, 1, 4'hA, 0);
    sym(4'hA); sym(4'hA);
    check("t7_en_drop", match8, 0);

    // Match and clear on the same edge: pulse still emitted, count cleared.
    do_load(12'hA5A);
    sym(4'hA); sym(4'h5);
    cyc(0, 1, 0, cur_pat, 1, 4'hA, 1);
    check("t8_pulse", match8, 1);
    check("t8_cnt",   cnt8,   0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      bit r, e, l, v, c;
      logic [11:0] p;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 39) != 0);
      l = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 3) != 0);
      p = {pick_sym(), pick_sym(), pick_sym()};
      if (l) cur_pat = p;
      cyc(r, e, l, l ? p : cur_pat, v, pick_sym(), c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pat_det.md
Name: pat_det

Overview:
- Downstream consumer of the 4-bit pseudo-random pattern generator output stream.
- Slides a window over incoming symbols and compares it against a loadable target sequence of SEQ_LEN symbols. Overlapping matches count.
- Emits a one-cycle match pulse, a saturating match count and a sticky saturation flag for the top-level display/compare logic.

Parameters:
- SYM_W, 4, symbol width in bits; equals the generator data width.
- SEQ_LEN, 3, number of symbols in the target sequence (legal range 2..8).
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- res  in  1  synchronous, active-high reset.
- en  in  1  detector enable; low forces IDLE.
- load  in  1  latch pattern_in as the new target and restart window fill.
- pattern_in  in  SEQ_LEN*SYM_W  target sequence. Bits [SYM_W-1:0] are the last (newest) symbol; the top slice is the first symbol.
- in_valid  in  1  data_in carries a symbol this cycle.
- data_in  in  SYM_W  symbol from the generator.
- match  out  1  one-cycle pulse: the window ending with the last accepted symbol equals the target.
- match_cnt  out  CNT_W  number of matches since reset or clr_cnt; saturates.
- cnt_sat  out  1  sticky; set when match_cnt reaches all-ones.
- clr_cnt  in  1  clear match_cnt and cnt_sat.
- busy  out  1  high in FILL or RUN.

Behaviour:
- Reset (res=1, sampled at rising clk) overrides all other inputs:
  - match=0, match_cnt=0, cnt_sat=0, busy=0.
  - Target register = 0, window = 0, fill count = 0, state = IDLE.
- State encodings: IDLE, FILL, RUN.
- IDLE:
  - Symbols are ignored; busy=0.
  - en=1 moves to FILL with fill count 0 on the next edge.
- FILL:
  - Each accepted symbol (in_valid=1) shifts into the window: window <= {window[(SEQ_LEN-1)*SYM_W-1:0], data_in}.
  - Fill count increments on each accepted symbol.
  - When the SEQ_LEN-th symbol is accepted, state -> RUN. The compare is performed on that same edge.
- RUN:
  - Every accepted symbol shifts the window and compares the new window against the target.
  - Equal -> match=1 for exactly the following cycle.
- Latency: match is high in the cycle immediately after the clk edge that sampled the final matching symbol (1 cycle).
- Gaps: in_valid=0 holds window, fill count and state. Gaps do not break a partially received sequence.
- Overlap: matches may share symbols. With target A,5,A, the stream A,5,A,5,A gives two matches.
- en deassert in FILL/RUN: next state IDLE, fill count cleared, match=0. Window contents are don't-care.
- load=1 (not in reset):
  - Target <= pattern_in and fill count <= 0.
  - State <= FILL if en=1, else IDLE.
  - A symbol presented in the same cycle is dropped, and no match is generated on that edge.
- Counter:
  - Increments on every match edge until all-ones, then holds.
  - cnt_sat sets on the edge where match_cnt becomes all-ones and stays set until clr_cnt or reset.
- clr_cnt:
  - match_cnt <= 0 and cnt_sat <= 0.
  - If a match occurs on the same edge, clear wins: count = 0, but the match pulse is still emitted.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package pat_pkg:
  - State encoding constants IDLE=2'd0, FILL=2'd1, RUN=2'd2.
  - Default SYM_W.
  - Reused by the generator top level.
- One natural sub-module, sym_window: parameterised SEQ_LEN x SYM_W shift register with shift-enable and synchronous clear, exposing the full window vector.
- The FSM, compare and counter stay in pat_det.

Test Plan (SEQ_LEN=3, SYM_W=4, CNT_W=8 unless stated):
- Reset then load 0xA5A with en=1; stream A,5,A,5,A back-to-back -> match pulses 1 cycle after the 3rd and 5th symbols; match_cnt=2; cnt_sat=0.
- Same target; stream A,(valid=0 for 3 cycles),5,A -> single match 1 cycle after the final A; no match during the gap; match_cnt=1.
- Stream 3,A,5,7,A,5,A -> exactly one match, after the last symbol; no false match on A,5,7.
- CNT_W=2; stream A,5,A repeated 5 times contiguously -> match_cnt goes 1,2,3,3,3; cnt_sat rises with the 3rd match. Then clr_cnt -> match_cnt=0, cnt_sat=0.
- Mid-sequence: after A,5 accepted, pulse load with 0x123 while data_in=A, valid=1 -> no match. Then 1,2,3 -> match; A is not part of the window.
- Reset asserted after two symbols of A,5,A -> all outputs 0 and state IDLE. Sending the final A alone produces no match. Full A,5,A after load+en produces a match.
